// File: rtl/kong_keypad_if.sv
// Keypad pins and player-request bundle for the Kong keypad controller.
// The controller side takes the master modport; keypad/player side takes slave.
interface kong_keypad_if;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic        ask_move_right;
    logic        ask_move_left;
    logic        ask_move_up;
    logic        ask_move_down;
    logic        ask_move_jump;
    logic [15:0] keys_stable;

    modport master (
        input  col_in,
        output row_out,
        output ask_move_right,
        output ask_move_left,
        output ask_move_up,
        output ask_move_down,
        output ask_move_jump,
        output keys_stable
    );

    modport slave (
        output col_in,
        input  row_out,
        input  ask_move_right,
        input  ask_move_left,
        input  ask_move_up,
        input  ask_move_down,
        input  ask_move_jump,
        input  keys_stable
    );
endinterface

// File: rtl/kong_keypad_ctrl.sv
// 4x4 matrix keypad scanner with whole-image debounce, producing Kong
// movement request levels and a one-clock jump pulse per accepted press.
module kong_keypad_ctrl #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int KEY_UP         = 1,
    parameter int KEY_LEFT       = 4,
    parameter int KEY_JUMP       = 5,
    parameter int KEY_RIGHT      = 6,
    parameter int KEY_DOWN       = 9
) (
    input  logic          clk,
    input  logic          resetN,
    kong_keypad_if.master kp
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int M_W   = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [M_W-1:0]   M_FULL   = M_W'(DEBOUNCE_SCANS);
    localparam logic [M_W-1:0]   M_ONE    = M_W'(1);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("kong_keypad_ctrl: SCAN_DIV must be at least 2");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
        $error("kong_keypad_ctrl: DEBOUNCE_SCANS must be at least 1");
    end
    if (KEY_UP > 15 || KEY_LEFT > 15 || KEY_JUMP > 15 ||
        KEY_RIGHT > 15 || KEY_DOWN > 15) begin : g_bad_key
        $error("kong_keypad_ctrl: key indices must be 0..15");
    end

    logic [CNT_W-1:0] cnt;
    logic [1:0]       row;
    logic [15:0]      raw;
    logic [15:0]      cand;
    logic [M_W-1:0]   m;
    logic [15:0]      stable;
    logic             jump;

    logic             sample;
    logic             scan_end;
    logic [15:0]      image;
    logic             image_changed;
    logic [M_W-1:0]   m_next;
    logic             accept;

    function automatic logic [M_W-1:0] sat_inc(input logic [M_W-1:0] v);
        return (v >= M_FULL) ? M_FULL : v + M_ONE;
    endfunction

    assign sample   = (cnt == CNT_LAST);
    assign scan_end = sample && (row == 2'd3);

    // Stored rows with the currently driven row's live sample merged in;
    // at scan end this is the full image without waiting for the register.
    always_comb begin
        image = raw;
        image[{row, 2'b00} +: 4] = ~kp.col_in;
    end

    assign image_changed = (image != cand);

    always_comb begin
        m_next = m;
        if (scan_end) begin
            m_next = image_changed ? M_ONE : sat_inc(m);
        end
    end

    assign accept = scan_end && (m_next == M_FULL);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt <= '0;
            row <= 2'd0;
        end else if (sample) begin
            cnt <= '0;
            row <= row + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            raw <= '0;
        end else if (sample) begin
            raw <= image;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cand <= '0;
            m    <= '0;
        end else begin
            m <= m_next;
            if (scan_end && image_changed) begin
                cand <= image;
            end
        end
    end

    // Jump fires on the same edge that first accepts the key, so the pulse
    // occupies exactly the first clock in which keys_stable shows it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            stable <= '0;
            jump   <= 1'b0;
        end else begin
            jump <= accept && image[KEY_JUMP] && !stable[KEY_JUMP];
            if (accept) begin
                stable <= image;
            end
        end
    end

    // Rows idle high while reset is held, and row 0 is driven from the very
    // first clock after release.
    assign kp.row_out        = resetN ? ~(4'b0001 << row) : 4'b1111;
    assign kp.keys_stable    = stable;
    assign kp.ask_move_right = stable[KEY_RIGHT];
    assign kp.ask_move_left  = stable[KEY_LEFT];
    assign kp.ask_move_up    = stable[KEY_UP];
    assign kp.ask_move_down  = stable[KEY_DOWN];
    assign kp.ask_move_jump  = jump;

endmodule

// File: tb/tb_kong_keypad_ctrl.sv
// Bench for kong_keypad_ctrl: a keypad matrix model drives the columns and a
// scoreboard of expected keys_stable changes is checked as they appear.
module tb_kong_keypad_ctrl;

    localparam int SD   = 4;
    localparam int DB   = 3;
    localparam int SCAN = 4 * SD;

    typedef struct {
        logic [15:0] val;
        int          at_edge;
        logic        jump;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic [15:0] pressed;
    logic [3:0]  col_drv;
    logic        mon_en;
    int          cyc;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_jump  = 0;
    exp_t        sb_q[$];

    kong_keypad_if kif ();

    kong_keypad_ctrl #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .kp     (kif)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_drv = 4'hF;
        for (int rr = 0; rr < 4; rr++) begin
            if (!kif.row_out[rr]) begin
                for (int cc = 0; cc < 4; cc++) begin
                    if (pressed[rr*4+cc]) col_drv[cc] = 1'b0;
                end
            end
        end
    end
    assign kif.col_in = col_drv;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    function automatic logic [4:0] asks();
        return {kif.ask_move_right, kif.ask_move_left, kif.ask_move_up,
                kif.ask_move_down, kif.ask_move_jump};
    endfunction

    task automatic push(input logic [15:0] val, input int at_edge, input logic jmp);
        exp_t e;
        e.val = val; e.at_edge = at_edge; e.jump = jmp;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic start_test(input logic [15:0] keys);
        @(negedge clk);
        #1 mon_en = 1'b0;
        #1 resetN = 1'b0;
        pressed = keys;
        n_jump  = 0;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        #1 mon_en = 1'b1;
    endtask

    // Output monitor: every keys_stable change must match the next scoreboard entry.
    initial begin : monitor
        logic [15:0] ks_prev;
        exp_t        e;
        ks_prev = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                ks_prev = kif.keys_stable;
            end else begin
                if (kif.keys_stable !== ks_prev) begin
                    if (sb_q.size() == 0) begin
                        chk("ks_unexpected", kif.keys_stable, ks_prev);
                    end else begin
                        e = sb_q.pop_front();
                        chk("ks_value", kif.keys_stable, e.val);
                        chk("ks_edge", cyc, e.at_edge);
                        chk("ask_dir", {kif.ask_move_right, kif.ask_move_left,
                                        kif.ask_move_up, kif.ask_move_down},
                            {e.val[6], e.val[4], e.val[1], e.val[9]});
                        chk("jump_on_accept", kif.ask_move_jump, e.jump);
                    end
                    ks_prev = kif.keys_stable;
                end else if (kif.ask_move_jump) begin
                    chk("jump_stray", kif.ask_move_jump, 1'b0);
                end
                if (kif.ask_move_jump) n_jump++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] exp_row;
        resetN  = 1'b0;
        pressed = '0;
        mon_en  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_row_out", kif.row_out, 4'hF);
        chk("rst_asks", asks(), 5'd0);
        chk("rst_keys", kif.keys_stable, 16'h0);

        // Row walk with no keys
        resetN = 1'b1;
        #1 mon_en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            exp_row = ~(4'b0001 << (((k - 1) / 4) % 4));
            chk("row_walk", kif.row_out, exp_row);
            @(negedge clk);
        end
        wait_cyc(64);
        chk("idle_asks", asks(), 5'd0);
        chk("idle_sb", sb_q.size(), 0);

        // Clean right press held from reset release
        start_test(16'h0040);
        push(16'h0040, 3 * SCAN, 1'b0);
        wait_cyc(3 * SCAN - 1);
        chk("right_before", kif.ask_move_right, 1'b0);
        wait_cyc(4 * SCAN);
        chk("right_level", kif.ask_move_right, 1'b1);
        chk("right_others", asks(), 5'b10000);
        chk("right_sb", sb_q.size(), 0);

        // Bounce: pressed scans 1-2, released scan 3, pressed scans 4-6
        start_test(16'h0010);
        push(16'h0010, 6 * SCAN, 1'b0);
        wait_cyc(2 * SCAN);
        pressed = 16'h0000;
        wait_cyc(3 * SCAN);
        pressed = 16'h0010;
        wait_cyc(6 * SCAN - 1);
        chk("bounce_hold", kif.ask_move_left, 1'b0);
        wait_cyc(7 * SCAN);
        chk("bounce_left", kif.ask_move_left, 1'b1);
        chk("bounce_sb", sb_q.size(), 0);

        // Jump: press, hold, release, press again
        start_test(16'h0020);
        push(16'h0020, 3 * SCAN, 1'b1);
        wait_cyc(13 * SCAN);
        pressed = 16'h0000;
        push(16'h0000, 16 * SCAN, 1'b0);
        wait_cyc(19 * SCAN);
        pressed = 16'h0020;
        push(16'h0020, 22 * SCAN, 1'b1);
        wait_cyc(25 * SCAN);
        chk("jump_count", n_jump, 2);
        chk("jump_sb", sb_q.size(), 0);

        // Simultaneous left+right, release, then second key restarts debounce
        start_test(16'h0050);
        push(16'h0050, 3 * SCAN, 1'b0);
        wait_cyc(4 * SCAN);
        chk("both_lr", {kif.ask_move_left, kif.ask_move_right}, 2'b11);
        pressed = 16'h0000;
        push(16'h0000, 7 * SCAN, 1'b0);
        wait_cyc(8 * SCAN);
        pressed = 16'h0040;
        push(16'h0040, 11 * SCAN, 1'b0);
        wait_cyc(12 * SCAN);
        pressed = 16'h0050;
        push(16'h0050, 15 * SCAN, 1'b0);
        wait_cyc(15 * SCAN - 1);
        chk("second_key_hold", kif.keys_stable, 16'h0040);
        wait_cyc(16 * SCAN);
        chk("multi_sb", sb_q.size(), 0);

        // Async reset mid-row while right is asserted
        start_test(16'h0040);
        push(16'h0040, 3 * SCAN, 1'b0);
        wait_cyc(3 * SCAN + 10);
        chk("pre_reset_right", kif.ask_move_right, 1'b1);
        #1 mon_en = 1'b0;
        #1 resetN = 1'b0;
        #1;
        chk("async_row_out", kif.row_out, 4'hF);
        chk("async_asks", asks(), 5'd0);
        chk("async_keys", kif.keys_stable, 16'h0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        #1;
        chk("restart_row0", kif.row_out, 4'b1110);
        mon_en = 1'b1;
        push(16'h0040, 3 * SCAN, 1'b0);
        wait_cyc(3 * SCAN - 1);
        chk("restart_debounce", kif.ask_move_right, 1'b0);
        wait_cyc(4 * SCAN);
        chk("restart_right", kif.ask_move_right, 1'b1);
        chk("restart_sb", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kong_keypad_ctrl.md
Name: kong_keypad_ctrl

Overview:
- Scans the 4x4 matrix keypad and debounces it. Produces the movement request inputs for the Kong player logic: ask_move_right/left/up/down/jump.
- Sits between the keypad pins and the player logic.
- Direction requests are debounced levels. Jump is a one-clock pulse per press.
- The player logic accumulates requests per frame, so no frame alignment is needed here.

Parameters:
- SCAN_DIV, 1000: clocks each row is driven. Columns are sampled on the last clock of the row period. Minimum 2.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan images required before acceptance. Minimum 1.
- KEY_UP, 1: key index (row*4+col) mapped to up.
- KEY_LEFT, 4: key index mapped to left.
- KEY_JUMP, 5: key index mapped to jump.
- KEY_RIGHT, 6: key index mapped to right.
- KEY_DOWN, 9: key index mapped to down.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- col_in  in  4  keypad columns, active-low (pulled up; low = pressed key in driven row). Already synchronised externally.
- row_out  out  4  keypad rows, active-low, one-hot-zero while scanning
- ask_move_right  out  1  debounced level, high while right key held
- ask_move_left  out  1  debounced level
- ask_move_up  out  1  debounced level
- ask_move_down  out  1  debounced level
- ask_move_jump  out  1  single-clock pulse on debounced press of jump key
- keys_stable  out  16  debounced key image, bit i = key index i pressed

Behaviour:
- Reset (async, resetN low) values:
  - row_out=4'b1111
  - row index r=0, row counter cnt=0
  - raw image, candidate image and match count m all 0
  - keys_stable=0; all ask_* outputs 0
- Scan counter:
  - cnt runs 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, r advances 0->1->2->3->0.
  - row_out drives bit r low for the whole row period, including the first clock after reset release.
- Sampling: at cnt==SCAN_DIV-1, raw[r*4+c] <= ~col_in[c] for c=0..3.
- Scan end: the sample clock of row 3. The full image is the three stored rows plus the row-3 bits sampled that clock.
- Debounce, evaluated at scan end:
  - If image != candidate: candidate<=image, m<=1.
  - Else: m<=min(m+1, DEBOUNCE_SCANS).
  - If the resulting m == DEBOUNCE_SCANS: keys_stable<=image, in the same clock edge.
  - A saturated m with an unchanged image rewrites the same value, which has no effect.
- Outputs:
  - Direction ask_* are keys_stable[KEY_*] (registered, no extra latency).
  - Left and right, or up and down, may both be high. Arbitration belongs to the consumer.
- Jump pulse:
  - ask_move_jump is registered; it is high for exactly the clock after keys_stable[KEY_JUMP] goes 0->1.
  - Holding the key gives no repeat. A release followed by a re-acceptance gives a new pulse.
- Latency, press to output, with a clean press: between (DEBOUNCE_SCANS-1)*4*SCAN_DIV and DEBOUNCE_SCANS*4*SCAN_DIV clocks after the press becomes visible at a sample.
- Release is debounced identically, because the image compare covers release as well as press.
- Bounce: any image change during counting restarts m at 1 and leaves keys_stable unchanged.
- Multiple keys: the full image is debounced as a unit. Pressing a second key restarts debouncing for all keys, but already-stable keys stay asserted until a new image is accepted.
- Reset mid-scan: everything returns to reset values immediately. A jump pulse in flight is dropped. Scanning restarts at row 0.
- Widths:
  - cnt is $clog2(SCAN_DIV) bits.
  - m is $clog2(DEBOUNCE_SCANS+1) bits.
  - No overflow, because the counters saturate or wrap explicitly.

Test Plan:
- Reset and row walk:
  - Stimulus: SCAN_DIV=4, DEBOUNCE_SCANS=3, no keys.
  - Required: row_out=1111 during reset, then 1110 for clocks 1-4, 1101 for 5-8, 1011 for 9-12, 0111 for 13-16, then repeats. All ask_* stay 0.
- Clean right press:
  - Stimulus: key 6 (row1, col2) held from reset release.
  - Required: ask_move_right rises right after the scan ending at clock 48 (3rd scan end). keys_stable=16'h0040. Other ask_* stay 0.
- Bounce rejection:
  - Stimulus: key 4 pressed for scans 1-2, released for scan 3, pressed for scans 4-6.
  - Required: ask_move_left stays 0 until the 6th scan end (clock 96), then goes 1.
- Jump pulse:
  - Stimulus: key 5 held for 200 clocks, released for 100, pressed again.
  - Required: ask_move_jump is high for exactly 1 clock after each acceptance (2 pulses total), and never high while the key is merely held.
- Release and simultaneous keys:
  - Stimulus: keys 4 and 6 held until accepted, then both released.
  - Required: left and right are both 1 together, and both go 0 exactly 3 scans after release.
- Async reset mid-operation:
  - Stimulus: resetN pulsed low while right is asserted and mid-row.
  - Required: all outputs 0 and row_out=1111 immediately, without waiting for a clock. After release, scanning restarts at row 0 and needs a full 3-scan debounce again.
